// File: rtl/kovacs_indicator_decoder.sv
// Receive-side decoder for the Kovacs three-level protocol indicator: classifies ADC
// samples, debounces level changes, tracks the phase sequence and measures phase lengths.
module kovacs_indicator_decoder #(
    parameter int CNT_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic signed [15:0]      indicator_i,
    input  logic signed [15:0]      th_low_i,
    input  logic signed [15:0]      th_high_i,
    input  logic        [15:0]      min_hold_i,
    input  logic                    clear_i,
    output logic        [1:0]       state_o,
    output logic                    phase_valid_o,
    output logic        [1:0]       phase_id_o,
    output logic        [CNT_W-1:0] phase_len_o,
    output logic        [CNT_W-1:0] cycle_count_o,
    output logic                    seq_err_o
);

    typedef enum logic [1:0] {
        FSM_UNKNOWN = 2'd0,
        FSM_ACQUIRE = 2'd1,
        FSM_LOCKED  = 2'd2
    } fsm_e;

    localparam logic [1:0]       LVL_LOW     = 2'd0;
    localparam logic [1:0]       LVL_RESC    = 2'd1;
    localparam logic [1:0]       LVL_FULL    = 2'd2;
    localparam logic [1:0]       LVL_UNKNOWN = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    fsm_e             fsm_reg, fsm_next;
    logic [1:0]       class_reg, class_next;
    logic [1:0]       cand_reg;
    logic [15:0]      run_reg, run_next;
    logic [15:0]      hold_len;
    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] dur_reg, dur_next;
    logic             valid_reg, valid_next;
    logic [1:0]       id_reg, id_next;
    logic [CNT_W-1:0] len_reg, len_next;
    logic [CNT_W-1:0] cyc_reg, cyc_next;
    logic             err_reg, err_next;
    logic             accept;
    logic             legal;

    // LOW is tested first so it wins when the thresholds overlap.
    always_comb begin
        if (indicator_i < th_low_i) begin
            class_next = LVL_LOW;
        end else if (indicator_i >= th_high_i) begin
            class_next = LVL_FULL;
        end else begin
            class_next = LVL_RESC;
        end
    end

    // run_next is the length of the current class run including this cycle.
    always_comb begin
        hold_len = (min_hold_i == 16'd0) ? 16'd1 : min_hold_i;
        if (class_reg != cand_reg) begin
            run_next = 16'd1;
        end else if (run_reg == 16'hFFFF) begin
            run_next = run_reg;
        end else begin
            run_next = run_reg + 16'd1;
        end
        accept = (class_reg != state_reg) && (run_next >= hold_len);
        legal  = ((state_reg == LVL_LOW)  && (class_reg == LVL_FULL)) ||
                 ((state_reg == LVL_FULL) && (class_reg == LVL_RESC)) ||
                 ((state_reg == LVL_RESC) && (class_reg == LVL_LOW));
    end

    always_comb begin
        fsm_next   = fsm_reg;
        state_next = state_reg;
        dur_next   = (dur_reg == CNT_MAX) ? dur_reg : dur_reg + CNT_ONE;
        valid_next = 1'b0;
        id_next    = id_reg;
        len_next   = len_reg;
        cyc_next   = cyc_reg;
        err_next   = err_reg;
        if (accept) begin
            state_next = class_reg;
            dur_next   = CNT_ONE;
            case (fsm_reg)
                FSM_UNKNOWN: fsm_next = FSM_ACQUIRE;
                FSM_ACQUIRE: begin
                    // The first transition closes a partial phase: checked but never reported.
                    fsm_next = FSM_LOCKED;
                    if (!legal) begin
                        err_next = 1'b1;
                    end
                end
                FSM_LOCKED: begin
                    if (legal) begin
                        valid_next = 1'b1;
                        id_next    = state_reg;
                        len_next   = dur_reg;
                        if ((state_reg == LVL_RESC) && (cyc_reg != CNT_MAX)) begin
                            cyc_next = cyc_reg + CNT_ONE;
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: fsm_next = FSM_UNKNOWN;
            endcase
        end
        if (clear_i) begin
            cyc_next = '0;
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_reg   <= FSM_UNKNOWN;
            class_reg <= LVL_UNKNOWN;
            cand_reg  <= LVL_UNKNOWN;
            run_reg   <= 16'd0;
            state_reg <= LVL_UNKNOWN;
            dur_reg   <= '0;
            valid_reg <= 1'b0;
            id_reg    <= 2'd0;
            len_reg   <= '0;
            cyc_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            fsm_reg   <= fsm_next;
            class_reg <= class_next;
            cand_reg  <= class_reg;
            run_reg   <= run_next;
            state_reg <= state_next;
            dur_reg   <= dur_next;
            valid_reg <= valid_next;
            id_reg    <= id_next;
            len_reg   <= len_next;
            cyc_reg   <= cyc_next;
            err_reg   <= err_next;
        end
    end

    assign state_o       = state_reg;
    assign phase_valid_o = valid_reg;
    assign phase_id_o    = id_reg;
    assign phase_len_o   = len_reg;
    assign cycle_count_o = cyc_reg;
    assign seq_err_o     = err_reg;

endmodule

// File: tb/tb_kovacs_indicator_decoder.sv
// Self-checking bench for kovacs_indicator_decoder: randomized level sequences are
// scored against a history-window model of accepted levels and phase reports.
module tb_kovacs_indicator_decoder;

    typedef struct {
        int     id;
        longint len;
    } rep_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] indicator = '0;
    logic signed [15:0] th_low = 16'sd2048;
    logic signed [15:0] th_high = 16'sd6144;
    logic        [15:0] min_hold = 16'd4;
    logic               clear = 1'b0;

    logic [1:0]  st32, id32, st8, id8;
    logic        pv32, err32, pv8, err8;
    logic [31:0] len32, cc32;
    logic [7:0]  len8, cc8;

    int     lvl_q[$];
    bit     clr_q[$];
    rep_t   obs32_q[$], obs8_q[$], exp_q[$];
    longint exp_cnt;
    bit     exp_err;
    int     exp_state;
    bit     exact_mode = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;

    kovacs_indicator_decoder #(.CNT_W(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .indicator_i(indicator), .th_low_i(th_low),
        .th_high_i(th_high), .min_hold_i(min_hold), .clear_i(clear), .state_o(st32),
        .phase_valid_o(pv32), .phase_id_o(id32), .phase_len_o(len32),
        .cycle_count_o(cc32), .seq_err_o(err32)
    );

    kovacs_indicator_decoder #(.CNT_W(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .indicator_i(indicator), .th_low_i(th_low),
        .th_high_i(th_high), .min_hold_i(min_hold), .clear_i(clear), .state_o(st8),
        .phase_valid_o(pv8), .phase_id_o(id8), .phase_len_o(len8),
        .cycle_count_o(cc8), .seq_err_o(err8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pv32) obs32_q.push_back('{id: int'(id32), len: longint'(len32)});
            if (pv8)  obs8_q.push_back('{id: int'(id8), len: longint'(len8)});
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] sample_for(int lvl);
        int v;
        if (exact_mode) begin
            v = (lvl == 0) ? 0 : (lvl == 1) ? 4096 : 8191;
        end else begin
            case (lvl)
                0: v = ($urandom_range(0, 3) == 0) ? 2047 : int'($urandom_range(0, 3047)) - 1000;
                1: v = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 2048 : 6143)
                                                   : int'($urandom_range(2048, 6143));
                default: v = ($urandom_range(0, 3) == 0) ? 6144 : int'($urandom_range(6144, 9000));
            endcase
        end
        return v[15:0];
    endfunction

    task automatic add_seg(input int lvl, input int len);
        repeat (len) begin
            lvl_q.push_back(lvl);
            clr_q.push_back(1'b0);
        end
    endtask

    // A level is accepted once the last H classified samples all show it and it differs
    // from the accepted one. Phase length is the distance between two acceptances.
    task automatic model(input int mh, input int w);
        longint maxv;
        int h, acc, ntrans, last_t, n;
        maxv = (longint'(1) << w) - 1;
        h = (mh == 0) ? 1 : mh;
        acc = 3; ntrans = 0; last_t = 0; n = lvl_q.size();
        exp_q.delete(); exp_cnt = 0; exp_err = 1'b0;
        for (int j = 1; j <= n; j++) begin
            int t, v;
            bit same, ok;
            t = j - 1;
            if (t >= h - 1) begin
                v = lvl_q[t];
                same = 1'b1;
                for (int k = 0; k < h; k++) if (lvl_q[t-k] != v) same = 1'b0;
                if (same && v != acc) begin
                    ntrans++;
                    ok = (acc == 0 && v == 2) || (acc == 2 && v == 1) || (acc == 1 && v == 0);
                    if (ntrans >= 2 && !ok) begin
                        exp_err = 1'b1;
                    end else if (ntrans >= 3) begin
                        exp_q.push_back('{id: acc, len: ((t - last_t) > maxv) ? maxv : longint'(t - last_t)});
                        if (acc == 1 && exp_cnt < maxv) exp_cnt++;
                    end
                    last_t = t;
                    acc = v;
                end
            end
            if (j < n && clr_q[j]) begin
                exp_cnt = 0;
                exp_err = 1'b0;
            end
        end
        exp_state = acc;
    endtask

    task automatic drive_seq(input int mh);
        min_hold = 16'(mh);
        obs32_q.delete();
        obs8_q.delete();
        for (int j = 0; j < lvl_q.size(); j++) begin
            indicator = sample_for(lvl_q[j]);
            clear = clr_q[j];
            @(posedge clk); #1;
        end
        clear = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        indicator = '0;
        clear = 1'b0;
        min_hold = 16'd4;
        lvl_q.delete();
        clr_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (st32 !== 2'd3) begin n_fail++; $display("FAIL reset state: got %0d expected 3", st32); end
        n_checks++; if (pv32 !== 1'b0) begin n_fail++; $display("FAIL reset phase_valid: got %0b expected 0", pv32); end
        n_checks++; if (id32 !== 2'd0) begin n_fail++; $display("FAIL reset phase_id: got %0d expected 0", id32); end
        n_checks++; if (len32 !== 32'd0) begin n_fail++; $display("FAIL reset phase_len: got %0d expected 0", len32); end
        n_checks++; if (cc32 !== 32'd0) begin n_fail++; $display("FAIL reset cycle_count: got %0d expected 0", cc32); end
        n_checks++; if (err32 !== 1'b0) begin n_fail++; $display("FAIL reset seq_err: got %0b expected 0", err32); end
        n_checks++; if (len8 !== 8'd0 || cc8 !== 8'd0) begin n_fail++; $display("FAIL reset w8: got len=%0d cnt=%0d expected 0 0", len8, cc8); end
    endtask

    task automatic test_clean();
        do_reset();
        exact_mode = 1'b1;
        add_seg(0, 100); add_seg(2, 200); add_seg(1, 50); add_seg(0, 100); add_seg(2, 10);
        drive_seq(4);
        exact_mode = 1'b0;
        model(4, 32);
        n_checks++; if (obs32_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL clean n_reports: got %0d expected %0d", obs32_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs32_q.size()) begin
            n_checks++; if (obs32_q[i].id !== exp_q[i].id || obs32_q[i].len !== exp_q[i].len) begin n_fail++; $display("FAIL clean report[%0d]: got id=%0d len=%0d expected id=%0d len=%0d", i, obs32_q[i].id, obs32_q[i].len, exp_q[i].id, exp_q[i].len); end
        end
        n_checks++; if (cc32 !== 32'(exp_cnt)) begin n_fail++; $display("FAIL clean cycle_count: got %0d expected %0d", cc32, exp_cnt); end
        n_checks++; if (err32 !== exp_err) begin n_fail++; $display("FAIL clean seq_err: got %0b expected %0b", err32, exp_err); end
        n_checks++; if (st32 !== 2'(exp_state)) begin n_fail++; $display("FAIL clean state: got %0d expected %0d", st32, exp_state); end
    endtask

    task automatic test_latency(input int h);
        int k;
        do_reset();
        min_hold = 16'(h);
        indicator = 16'sd0;
        repeat (20) begin @(posedge clk); #1; end
        indicator = 16'sd8191;
        @(posedge clk); #1;
        k = 0;
        while (k < 40 && st32 !== 2'd2) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++; if (k !== h) begin n_fail++; $display("FAIL latency H=%0d: got %0d cycles expected %0d", h, k, h); end
    endtask

    task automatic test_glitch();
        do_reset();
        add_seg(0, 30); add_seg(2, 20); add_seg(1, 30); add_seg(0, 30); add_seg(2, 40);
        add_seg(0, 7); add_seg(2, 50); add_seg(1, 20); add_seg(0, 20); add_seg(2, 30);
        add_seg(0, 8); add_seg(2, 20);
        drive_seq(8);
        model(8, 32);
        n_checks++; if (obs32_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL glitch n_reports: got %0d expected %0d", obs32_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs32_q.size()) begin
            n_checks++; if (obs32_q[i].id !== exp_q[i].id || obs32_q[i].len !== exp_q[i].len) begin n_fail++; $display("FAIL glitch report[%0d]: got id=%0d len=%0d expected id=%0d len=%0d", i, obs32_q[i].id, obs32_q[i].len, exp_q[i].id, exp_q[i].len); end
        end
        n_checks++; if (cc32 !== 32'(exp_cnt)) begin n_fail++; $display("FAIL glitch cycle_count: got %0d expected %0d", cc32, exp_cnt); end
        n_checks++; if (err32 !== exp_err) begin n_fail++; $display("FAIL glitch seq_err: got %0b expected %0b", err32, exp_err); end
        n_checks++; if (st32 !== 2'(exp_state)) begin n_fail++; $display("FAIL glitch state: got %0d expected %0d", st32, exp_state); end
    endtask

    task automatic test_illegal_order();
        do_reset();
        add_seg(0, 30); add_seg(1, 30); add_seg(2, 30); add_seg(1, 30); add_seg(0, 30); add_seg(2, 10);
        drive_seq(4);
        model(4, 32);
        n_checks++; if (obs32_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL illegal n_reports: got %0d expected %0d", obs32_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs32_q.size()) begin
            n_checks++; if (obs32_q[i].id !== exp_q[i].id || obs32_q[i].len !== exp_q[i].len) begin n_fail++; $display("FAIL illegal report[%0d]: got id=%0d len=%0d expected id=%0d len=%0d", i, obs32_q[i].id, obs32_q[i].len, exp_q[i].id, exp_q[i].len); end
        end
        n_checks++; if (cc32 !== 32'(exp_cnt)) begin n_fail++; $display("FAIL illegal cycle_count: got %0d expected %0d", cc32, exp_cnt); end
        n_checks++; if (err32 !== exp_err) begin n_fail++; $display("FAIL illegal seq_err: got %0b expected %0b", err32, exp_err); end
    endtask

    task automatic test_clear();
        do_reset();
        add_seg(0, 20); add_seg(1, 20); add_seg(2, 20); add_seg(1, 20); add_seg(0, 20);
        clr_q[80 + 4] = 1'b1;  // coincides with acceptance of the RESCALED->LOW step
        add_seg(2, 20); add_seg(1, 20); add_seg(0, 20);
        drive_seq(4);
        model(4, 32);
        n_checks++; if (obs32_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL clear n_reports: got %0d expected %0d", obs32_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs32_q.size()) begin
            n_checks++; if (obs32_q[i].id !== exp_q[i].id || obs32_q[i].len !== exp_q[i].len) begin n_fail++; $display("FAIL clear report[%0d]: got id=%0d len=%0d expected id=%0d len=%0d", i, obs32_q[i].id, obs32_q[i].len, exp_q[i].id, exp_q[i].len); end
        end
        n_checks++; if (cc32 !== 32'(exp_cnt)) begin n_fail++; $display("FAIL clear cycle_count: got %0d expected %0d", cc32, exp_cnt); end
        n_checks++; if (err32 !== exp_err) begin n_fail++; $display("FAIL clear seq_err: got %0b expected %0b", err32, exp_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        add_seg(0, 20); add_seg(2, 20); add_seg(1, 20); add_seg(0, 20); add_seg(2, 261); add_seg(1, 10);
        drive_seq(4);
        model(4, 32);
        n_checks++; if (len32 !== 32'(exp_q[exp_q.size()-1].len)) begin n_fail++; $display("FAIL sat w32 phase_len: got %0d expected %0d", len32, exp_q[exp_q.size()-1].len); end
        model(4, 8);
        n_checks++; if (obs8_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL sat w8 n_reports: got %0d expected %0d", obs8_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs8_q.size()) begin
            n_checks++; if (obs8_q[i].id !== exp_q[i].id || obs8_q[i].len !== exp_q[i].len) begin n_fail++; $display("FAIL sat w8 report[%0d]: got id=%0d len=%0d expected id=%0d len=%0d", i, obs8_q[i].id, obs8_q[i].len, exp_q[i].id, exp_q[i].len); end
        end
        n_checks++; if (cc8 !== 8'(exp_cnt)) begin n_fail++; $display("FAIL sat w8 cycle_count: got %0d expected %0d", cc8, exp_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        add_seg(0, 20); add_seg(2, 20); add_seg(1, 20); add_seg(0, 20); add_seg(2, 10);
        drive_seq(4);
        rst_n = 1'b0;  // mid-cycle, inside the FULL phase
        #1;
        n_checks++; if (st32 !== 2'd3 || pv32 !== 1'b0 || id32 !== 2'd0) begin n_fail++; $display("FAIL async_reset state/valid/id: got %0d/%0b/%0d expected 3/0/0", st32, pv32, id32); end
        n_checks++; if (len32 !== 32'd0 || cc32 !== 32'd0 || err32 !== 1'b0) begin n_fail++; $display("FAIL async_reset len/cnt/err: got %0d/%0d/%0b expected 0/0/0", len32, cc32, err32); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lvl_q.delete(); clr_q.delete();
        add_seg(2, 20); add_seg(1, 20); add_seg(0, 20); add_seg(2, 5);
        drive_seq(4);
        model(4, 32);
        n_checks++; if (obs32_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL async_reset n_reports: got %0d expected %0d", obs32_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs32_q.size()) begin
            n_checks++; if (obs32_q[i].id !== exp_q[i].id || obs32_q[i].len !== exp_q[i].len) begin n_fail++; $display("FAIL async_reset report[%0d]: got id=%0d len=%0d expected id=%0d len=%0d", i, obs32_q[i].id, obs32_q[i].len, exp_q[i].id, exp_q[i].len); end
        end
        n_checks++; if (cc32 !== 32'(exp_cnt)) begin n_fail++; $display("FAIL async_reset cycle_count: got %0d expected %0d", cc32, exp_cnt); end
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            int mh, h, nseg;
            do_reset();
            mh = $urandom_range(0, 6);
            h = (mh == 0) ? 1 : mh;
            nseg = $urandom_range(6, 14);
            for (int s = 0; s < nseg; s++) add_seg($urandom_range(0, 2), $urandom_range(1, 3 * h + 2));
            foreach (clr_q[j]) clr_q[j] = ($urandom_range(0, 24) == 0);
            drive_seq(mh);
            model(mh, 32);
            n_checks++; if (obs32_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random[%0d] n_reports: got %0d expected %0d", it, obs32_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs32_q.size()) begin
                n_checks++; if (obs32_q[i].id !== exp_q[i].id || obs32_q[i].len !== exp_q[i].len) begin n_fail++; $display("FAIL random[%0d] report[%0d]: got id=%0d len=%0d expected id=%0d len=%0d", it, i, obs32_q[i].id, obs32_q[i].len, exp_q[i].id, exp_q[i].len); end
            end
            n_checks++; if (cc32 !== 32'(exp_cnt)) begin n_fail++; $display("FAIL random[%0d] cycle_count: got %0d expected %0d", it, cc32, exp_cnt); end
            n_checks++; if (err32 !== exp_err) begin n_fail++; $display("FAIL random[%0d] seq_err: got %0b expected %0b", it, err32, exp_err); end
            n_checks++; if (st32 !== 2'(exp_state)) begin n_fail++; $display("FAIL random[%0d] state: got %0d expected %0d", it, st32, exp_state); end
            $display("random[%0d] H=%0d samples=%0d reports=%0d", it, mh, lvl_q.size(), obs32_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_latency(1);
        test_latency(8);
        test_glitch();
        test_illegal_order();
        test_clear();
        test_saturation();
        test_async_reset();
        test_random(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kovacs_indicator_decoder.md
# kovacs_indicator_decoder

Receive-side decoder for the three-level protocol indicator driven by the Kovacs protocol generator (DAC codes 0 / 4096 / 8191 for LOW / RESCALED / FULL phases). It takes the digitized indicator back from an ADC channel and classifies each sample against two thresholds. Transitions are debounced, and the decoder reconstructs the generator's phase state, measures each completed phase length in clock cycles, counts full protocol cycles and flags illegal phase orderings. It sits next to the generator on the FPGA (loopback or second board) and feeds the acquisition/AXI register block.

## Interface
- CNT_W, 32, width of the duration counter, the phase-length output and the cycle counter
- clk_i  in  1  system clock (ADC clock domain)
- rst_ni  in  1  asynchronous, active-low reset
- indicator_i  in  16  signed ADC sample of the indicator signal
- th_low_i  in  16  signed; sample < th_low_i classifies as LOW
- th_high_i  in  16  signed; sample >= th_high_i classifies as FULL
- min_hold_i  in  16  debounce length H in cycles; 0 treated as 1
- clear_i  in  1  synchronous clear of cycle_count_o and seq_err_o
- state_o  out  2  accepted phase: 0 LOW, 1 RESCALED, 2 FULL, 3 UNKNOWN
- phase_valid_o  out  1  one-cycle pulse when a completed phase is reported
- phase_id_o  out  2  phase that just ended (0/1/2), valid with phase_valid_o
- phase_len_o  out  CNT_W  length of that phase in cycles, held until next report
- cycle_count_o  out  CNT_W  completed RESCALED→LOW transitions, saturating
- seq_err_o  out  1  sticky illegal-transition flag

## Operation
- Classification is registered each cycle into class_q.
  - LOW if indicator_i < th_low_i.
  - Otherwise FULL if indicator_i >= th_high_i.
  - Otherwise RESCALED.
  - LOW has priority when th_low_i > th_high_i.
- Debounce:
  - The candidate tracks class_q, and run_cnt counts consecutive cycles with class_q == candidate.
  - A change of class_q restarts run_cnt at 1.
  - The accepted level updates when class_q differs from state_o and run_cnt reaches H.
  - run_cnt saturates at 16 bits.
- FSM:
  - UNKNOWN: the first level held for H cycles is accepted. No report and no error. Go to ACQUIRE.
  - ACQUIRE: the first transition ends a partial phase. No report is made; legality is still checked. Go to LOCKED.
  - LOCKED: every accepted transition ends a full phase and is reported.
- Legal order is LOW→FULL→RESCALED→LOW. Any other accepted transition:
  - sets seq_err_o;
  - suppresses phase_valid_o for that transition;
  - does not increment cycle_count_o;
  - keeps LOCKED, so the next phase is measured normally.
- dur_cnt is loaded with 1 on every accepted-level update and increments every cycle, saturating at 2^CNT_W-1.
  - On a reported transition, phase_len_o <= dur_cnt (cycles the old level was held) and phase_id_o <= old state_o.
- A legal RESCALED→LOW transition in LOCKED increments cycle_count_o, saturating.
- clear_i zeroes cycle_count_o and seq_err_o only; the FSM, dur_cnt and state_o are unaffected.
  - If clear_i coincides with an increment or an error, clear wins.

## Timing
- Reset values:
  - state_o = 3 (UNKNOWN), phase_valid_o = 0, phase_id_o = 0, phase_len_o = 0, cycle_count_o = 0, seq_err_o = 0.
  - Internal state: FSM UNKNOWN, run_cnt = 0, dur_cnt = 0.
- Latency: a step sampled at edge N changes state_o at edge N+H. phase_valid_o, phase_id_o, phase_len_o and cycle_count_o update on that same edge.
- Clean steps are delayed equally at both edges, so phase_len_o equals the true input phase length exactly.
- Glitches shorter than H cycles never change state_o and never reset dur_cnt.
- A glitch to a third level during a pending transition restarts the debounce.
- Threshold or min_hold_i changes take effect on the next edge. A pending run compares against the new H.
- Asserting rst_ni low mid-phase returns everything to reset values immediately. The next phase after release is treated as partial.

## Test plan
- Clean sequence at H=4, th_low=2048, th_high=6144:
  - Stimulus: LOW 100, FULL 200, RESCALED 50, LOW 100, FULL 10 cycles (samples 0/8191/4096).
  - Required: first LOW not reported; FULL len=200 id=2; RESCALED len=50 id=1; cycle_count=1; LOW len=100 id=0; seq_err=0.
- Latency check at H=1 and H=8: the state_o change occurs exactly 1 and 8 cycles after the sampling edge of the step.
- Glitch rejection at H=8, during FULL:
  - 7-cycle dip to 0: no state change, and the FULL length includes the dip.
  - 8-cycle dip: LOW accepted, which is illegal (FULL→LOW), so seq_err=1 with no report.
- Illegal order LOW→RESCALED→FULL→RESCALED→LOW: seq_err set at the first transition; the subsequent legal phases are reported; cycle_count increments once.
- Saturation and clear:
  - Hold one level 2^CNT_W+5 cycles with reduced CNT_W=8: len=255.
  - Pulse clear_i together with a RESCALED→LOW transition: count=0, seq_err=0.
- Async reset mid-FULL: outputs return to reset values within the cycle; after release the first transition is unreported.
